apb_slave_regfile: RTL and testbench

//  APB3 completer with a word-addressed register file and programmable wait states.
//  It is the far end of the APB master (cmd_in/cmd_vld/transfer -> APB bus):
//  - it answers the master's PSEL/PENABLE/PWRITE/PADDR/PWDATA phases;
//  - it returns PRDATA/PREADY/PSLVERR.
//  It sits as slave 1 on the APB segment and is the memory the master tests write and read back.

---
 rtl/apb_slave_regfile_if.sv | 25 ++
 rtl/apb_slave_regfile.sv | 131 +++++++++++++
 tb/tb_apb_slave_regfile.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between one requester and one completer.
// The master drives the request phase; the slave returns ready, error and read data.
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB3 completer with a word-addressed register file.
// Every access phase is stretched by a fixed number of PREADY-low cycles.
module apb_slave_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    apb_slave_regfile_if.slave bus
);
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RIDX_W-1:0]     idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic [IDX_W-1:0]      idx_full;
    logic [RIDX_W-1:0]     idx_in;
    logic                  err_in;
    logic                  commit;

    // Out-of-range indices are always flagged as errors, so the truncated index is safe.
    assign idx_full = bus.paddr[ADDR_WIDTH-1:2];
    assign idx_in   = idx_full[RIDX_W-1:0];
    assign err_in   = (bus.paddr[1:0] != 2'b00) ||
                      ({1'b0, idx_full} >= (IDX_W+1)'(NUM_REGS));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    idx_d   = idx_in;
                    write_d = bus.pwrite;
                    err_d   = err_in;
                    wdata_d = bus.pwdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ST_DONE;
                        pready_d  = 1'b1;
                        pslverr_d = err_in;
                        if (!bus.pwrite && !err_in) begin
                            prdata_d = regs_q[idx_in];
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.psel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_DONE;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    if (!write_q && !err_q) begin
                        prdata_d = regs_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                commit  = write_q && bus.psel && bus.penable && !err_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            if (commit) begin
                regs_q[idx_q] <= wdata_q;
            end
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Drives three completers (1, 0 and 3 wait states) with directed and random APB
// transfers and compares them with a plain word-array model of each register file.
module tb_apb_slave_regfile;
    localparam int NDUT = 3;
    localparam int NREG = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_v    [NDUT];
    logic        psel_v    [NDUT];
    logic        penable_r;
    logic        pwrite_r;
    logic [11:0] paddr_r;
    logic [31:0] pwdata_r;
    logic        pready_v  [NDUT];
    logic        pslverr_v [NDUT];
    logic [31:0] prdata_v  [NDUT];

    apb_slave_regfile_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus0 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus1 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus2 ();

    assign bus0.psel = psel_v[0];  assign bus1.psel = psel_v[1];  assign bus2.psel = psel_v[2];
    assign bus0.penable = penable_r; assign bus1.penable = penable_r; assign bus2.penable = penable_r;
    assign bus0.pwrite = pwrite_r; assign bus1.pwrite = pwrite_r; assign bus2.pwrite = pwrite_r;
    assign bus0.paddr = paddr_r;   assign bus1.paddr = paddr_r;   assign bus2.paddr = paddr_r;
    assign bus0.pwdata = pwdata_r; assign bus1.pwdata = pwdata_r; assign bus2.pwdata = pwdata_r;
    assign pready_v[0] = bus0.pready;  assign pready_v[1] = bus1.pready;  assign pready_v[2] = bus2.pready;
    assign pslverr_v[0] = bus0.pslverr; assign pslverr_v[1] = bus1.pslverr; assign pslverr_v[2] = bus2.pslverr;
    assign prdata_v[0] = bus0.prdata;  assign prdata_v[1] = bus1.prdata;  assign prdata_v[2] = bus2.prdata;

    apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_REGS(NREG), .WAIT_CYCLES(1))
        u_dut0 (.clk_i(clk), .rstn_i(rstn_v[0]), .bus(bus0.slave));
    apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_REGS(NREG), .WAIT_CYCLES(0))
        u_dut1 (.clk_i(clk), .rstn_i(rstn_v[1]), .bus(bus1.slave));
    apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_REGS(NREG), .WAIT_CYCLES(3))
        u_dut2 (.clk_i(clk), .rstn_i(rstn_v[2]), .bus(bus2.slave));

    int          wait_of [NDUT] = '{1, 0, 3};
    logic [31:0] mdl [NDUT][NREG];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic bit addr_err(input logic [11:0] a);
        return (a % 4 != 0) || (a / 4 >= NREG);
    endfunction

    task automatic mdl_reset(input int d);
        for (int i = 0; i < NREG; i++) mdl[d][i] = '0;
    endtask

    // Starts at #1 after a posedge; returns at #1 after the posedge that ends the response.
    task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] data);
        int          n;
        bit          e;
        logic [31:0] exp_rd;
        e = addr_err(a);
        exp_rd = (wr || e) ? 32'h0 : mdl[d][a / 4];
        for (int k = 0; k < NDUT; k++) psel_v[k] = (k == d);
        penable_r = 1'b0; pwrite_r = wr; paddr_r = a; pwdata_r = data;
        @(posedge clk); #1;
        penable_r = 1'b1;
        n = 1;
        while (!pready_v[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("dut%0d %s a=%03h latency", d, wr ? "wr" : "rd", a), n, wait_of[d] + 1);
        check($sformatf("dut%0d %s a=%03h pslverr", d, wr ? "wr" : "rd", a), pslverr_v[d], e);
        if (!wr) check($sformatf("dut%0d rd a=%03h prdata", d, a), prdata_v[d], exp_rd);
        $display("dut%0d %s addr=0x%03h data=0x%08h err=%0d access_cycles=%0d",
                 d, wr ? "WR" : "RD", a, wr ? data : prdata_v[d], pslverr_v[d], n);
        if (wr && !e) mdl[d][a / 4] = data;
        @(posedge clk); #1;
        psel_v[d] = 1'b0; penable_r = 1'b0;
        check($sformatf("dut%0d a=%03h pready drop", d, a), pready_v[d], 1'b0);
        check($sformatf("dut%0d a=%03h prdata drop", d, a), prdata_v[d], 32'h0);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        bit          hi;
        logic [11:0] a;
        for (int k = 0; k < NDUT; k++) begin
            rstn_v[k] = 1'b0; psel_v[k] = 1'b0; mdl_reset(k);
        end
        penable_r = 1'b0; pwrite_r = 1'b0; paddr_r = '0; pwdata_r = '0;
        idle(3);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d reset pready", k), pready_v[k], 1'b0);
            check($sformatf("dut%0d reset pslverr", k), pslverr_v[k], 1'b0);
            check($sformatf("dut%0d reset prdata", k), prdata_v[k], 32'h0);
        end
        for (int k = 0; k < NDUT; k++) rstn_v[k] = 1'b1;
        idle(2);

        // One wait state: writes, read-back, never-written word, error addresses.
        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 12'(4 * i), 32'(4 * i));
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, 12'(4 * i), 32'h0);
        xfer(0, 1'b0, 12'h010, 32'h0);
        xfer(0, 1'b1, 12'h002, 32'hDEADBEEF);
        xfer(0, 1'b1, 12'h040, 32'hDEADBEEF);
        xfer(0, 1'b0, 12'h000, 32'h0);
        xfer(0, 1'b0, 12'h040, 32'h0);

        // Zero wait states, back-to-back write then read of the same word.
        xfer(1, 1'b1, 12'h008, 32'hA5A5A5A5);
        xfer(1, 1'b0, 12'h008, 32'h0);
        check("dut1 b2b readback", mdl[1][2], 32'hA5A5A5A5);
        idle(1);

        // Setup with penable already high must be ignored.
        psel_v[1] = 1'b1; penable_r = 1'b1; pwrite_r = 1'b1; paddr_r = 12'h00C; pwdata_r = 32'h1111_2222;
        hi = 1'b0;
        repeat (4) begin @(posedge clk); #1; hi |= pready_v[1]; end
        psel_v[1] = 1'b0; penable_r = 1'b0;
        check("dut1 penable-in-setup ignored", hi, 1'b0);
        idle(1);
        xfer(1, 1'b0, 12'h00C, 32'h0);

        // Three wait states: drop psel mid-wait, the write must be abandoned.
        xfer(2, 1'b1, 12'h004, 32'h0BAD_F00D);
        psel_v[2] = 1'b1; penable_r = 1'b0; pwrite_r = 1'b1; paddr_r = 12'h004; pwdata_r = 32'h1234_5678;
        @(posedge clk); #1;
        penable_r = 1'b1;
        @(posedge clk); #1;
        psel_v[2] = 1'b0; penable_r = 1'b0;
        hi = 1'b0;
        repeat (5) begin @(posedge clk); #1; hi |= pready_v[2]; end
        check("dut2 abort no pready", hi, 1'b0);
        xfer(2, 1'b0, 12'h004, 32'h0);

        // Reset while the response of a write is on the bus.
        psel_v[0] = 1'b1; penable_r = 1'b0; pwrite_r = 1'b1; paddr_r = 12'h00C; pwdata_r = 32'hFFFF_0000;
        @(posedge clk); #1;
        penable_r = 1'b1;
        for (int n = 0; n < 10 && !pready_v[0]; n++) begin @(posedge clk); #1; end
        check("dut0 pready before reset", pready_v[0], 1'b1);
        rstn_v[0] = 1'b0;
        #1;
        check("dut0 mid-reset pready", pready_v[0], 1'b0);
        check("dut0 mid-reset pslverr", pslverr_v[0], 1'b0);
        check("dut0 mid-reset prdata", prdata_v[0], 32'h0);
        mdl_reset(0);
        psel_v[0] = 1'b0; penable_r = 1'b0;
        idle(2);
        rstn_v[0] = 1'b1;
        idle(1);
        xfer(0, 1'b0, 12'h00C, 32'h0);
        xfer(0, 1'b0, 12'h000, 32'h0);

        // Random traffic on all three completers.
        for (int t = 0; t < 120; t++) begin
            int d;
            d = t % NDUT;
            a = 12'(4 * $urandom_range(0, 19));
            if ($urandom_range(0, 7) == 0) a = a | 12'($urandom_range(1, 3));
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
